// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU execute stage.
//   - DataWDefault / RegAwDefault: default operand and register-address widths
//   - alu_op_e: operation codes presented on in_op
//   - StIdle / StMul: execute-stage FSM state encoding
package alu_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned RegAwDefault = 5;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpSlt = 4'd5,
    OpSll = 4'd6,
    OpSrl = 4'd7,
    OpMul = 4'd8
  } alu_op_e;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : capture a/b and begin (ignored by caller while busy)
//   a, b       : operands
//   busy       : iterations in progress
//   done       : product valid; held until the next start
//   product    : low DATA_W bits of a*b
module mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              fin_q, fin_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    fin_d    = fin_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
      fin_d    = 1'b0;
    end else if (run_q && !fin_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      // Counter parks at the last index so the caller can observe completion.
      if (cnt_q == CntLast) fin_d = 1'b1;
      else                  cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      fin_q    <= fin_d;
    end
  end

  assign busy    = run_q && !fin_q;
  assign done    = fin_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_exec.sv
// alu_exec: single-issue ALU execute stage with a registered write-back output.
//   clk, rst_n            : clock and asynchronous active-low reset
//   in_valid/in_ready     : operation handshake (in_op, in_a, in_b, in_dest)
//   out_valid/out_ready   : result handshake (out_result, out_dest)
//   out_wen               : register-file write enable (valid and dest != 0)
// Single-cycle ops land in the output register on the edge after acceptance;
// MUL runs in mul_iter and lands DATA_W+1 edges after acceptance.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned REG_AW = RegAwDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [REG_AW-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_wen
);

  logic [0:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [REG_AW-1:0] out_dest_q, out_dest_d;
  logic [REG_AW-1:0] mul_dest_q, mul_dest_d;

  logic              out_free, in_fire, in_is_mul, mul_finish;
  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] alu_res;

  assign out_free   = !out_valid_q || out_ready;
  assign in_ready   = (state_q == StIdle) && !mul_busy && out_free;
  assign in_fire    = in_valid && in_ready;
  assign in_is_mul  = (in_op == OpMul);
  // A finished MUL waits in StMul until the output register can take it.
  assign mul_finish = (state_q == StMul) && mul_done && out_free;

  always_comb begin
    alu_res = '0;
    case (in_op)
      OpAdd:   alu_res = in_a + in_b;
      OpSub:   alu_res = in_a - in_b;
      OpAnd:   alu_res = in_a & in_b;
      OpOr:    alu_res = in_a | in_b;
      OpXor:   alu_res = in_a ^ in_b;
      OpSlt:   alu_res = DATA_W'($signed(in_a) < $signed(in_b));
      OpSll:   alu_res = in_a << in_b[4:0];
      OpSrl:   alu_res = in_a >> in_b[4:0];
      default: alu_res = '0;
    endcase
  end

  mul_iter #(
    .DATA_W(DATA_W)
  ) u_mul_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (in_fire && in_is_mul),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_dest_d   = out_dest_q;
    mul_dest_d   = mul_dest_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (in_fire) begin
      if (in_is_mul) begin
        state_d    = StMul;
        mul_dest_d = in_dest;
      end else begin
        out_valid_d  = 1'b1;
        out_result_d = alu_res;
        out_dest_d   = in_dest;
      end
    end else if (mul_finish) begin
      state_d      = StIdle;
      out_valid_d  = 1'b1;
      out_result_d = mul_product;
      out_dest_d   = mul_dest_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_dest_q   <= '0;
      mul_dest_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_dest_q   <= out_dest_d;
      mul_dest_q   <= mul_dest_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_dest   = out_dest_q;
  assign out_wen    = out_valid_q && (out_dest_q != '0);

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_dest = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_wen;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
  } exp_t;

  alu_exec #(
    .DATA_W(32),
    .REG_AW(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest),
    .out_wen    (out_wen)
  );

  always #5 clk = ~clk;

  // Reference: the arithmetic meaning of each opcode.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[4:0];
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_dest  = dest;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: out_valid=%b out_wen=%b, want 0 0", out_valid, out_wen);
    end
    checks++;
    if (out_result !== 32'd0 || out_dest !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h dest=%0d, want 0 0", out_result, out_dest);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_add_wrap();
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_wen !== 1'b1 || out_dest !== 5'd3) begin
      errors++;
      $display("FAIL add_wrap: valid=%b result=%h wen=%b dest=%0d, want 1 0 1 3",
               out_valid, out_result, out_wen, out_dest);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_directed_ops();
    logic [3:0]  ops [6] = '{4'd5, 4'd7, 4'd6, 4'd1, 4'd9, 4'd15};
    logic [31:0] as  [6] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'd5, 32'd0, 32'h1234, 32'hFFFF};
    logic [31:0] bs  [6] = '{32'd1, 32'd31, 32'h23, 32'd1, 32'h55, 32'h1};
    logic [31:0] exps[6] = '{32'd1, 32'd1, 32'h28, 32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], as[i], bs[i], 5'd9);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== exps[i]) begin
        errors++;
        $display("FAIL directed_op%0d: valid=%b result=%h, want 1 %h", ops[i], out_valid,
                 out_result, exps[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mul();
    logic [31:0] ra, rb;
    drive(4'd8, 32'h0001_2345, 32'h0001_0000, 5'd7);
    step();
    // Keep presenting a different op with new operands while MUL runs.
    ra = $urandom;
    rb = $urandom;
    drive(4'd0, ra, rb, 5'd12);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_ready_k0: in_ready=%b, want 0", in_ready);
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy_k%0d: in_ready=%b out_valid=%b, want 0 0", k, in_ready, out_valid);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h2345_0000 || out_dest !== 5'd7) begin
      errors++;
      $display("FAIL mul_result: valid=%b result=%h dest=%0d, want 1 23450000 7", out_valid,
               out_result, out_dest);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== ra + rb || out_dest !== 5'd12) begin
      errors++;
      $display("FAIL mul_followup: valid=%b result=%h dest=%0d, want 1 %h 12", out_valid,
               out_result, out_dest, ra + rb);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'd0, 32'd10, 32'd20, 5'd5);
    step();
    drive(4'd1, 32'd100, 32'd1, 5'd6);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd30 || out_dest !== 5'd5)
      begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%b valid=%b result=%h dest=%0d, want 0 1 1e 5", i,
                 in_ready, out_valid, out_result, out_dest);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd99 || out_dest !== 5'd6) begin
      errors++;
      $display("FAIL bp_next: valid=%b result=%h dest=%0d, want 1 63 6", out_valid, out_result,
               out_dest);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_dest_zero();
    drive(4'd3, 32'd5, 32'd2, 5'd0);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd7 || out_wen !== 1'b0) begin
      errors++;
      $display("FAIL dest_zero: valid=%b result=%h wen=%b, want 1 7 0", out_valid, out_result,
               out_wen);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    out_ready = 1'b1;
    drive(4'd8, $urandom, $urandom | 32'h1, 5'd4);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0) begin
      errors++;
      $display("FAIL midmul_reset: valid=%b result=%h, want 0 0", out_valid, out_result);
    end
    step();
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midmul_stale: %0d cycles with out_valid=1, want 0", stale);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midmul_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  // Random traffic with random backpressure, checked in order through a queue.
  task automatic test_random_stream();
    exp_t q[$];
    exp_t e;
    logic [3:0] op;
    int n_xfer = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8 && ($urandom % 3) != 0) op = 4'd2;
      in_valid  = (cyc < 540) && (($urandom % 4) != 0);
      in_op     = op;
      in_a      = $urandom;
      in_b      = ($urandom % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      in_dest   = 5'($urandom);
      out_ready = (cyc >= 540) || (($urandom % 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_xfer++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: result=%h dest=%0d with nothing outstanding", out_result,
                   out_dest);
        end else begin
          e = q.pop_front();
          if (out_result !== e.res || out_dest !== e.dest || out_wen !== (e.dest != 5'd0)) begin
            errors++;
            $display("FAIL stream_xfer%0d: result=%h dest=%0d wen=%b, want %h %0d %b", n_xfer,
                     out_result, out_dest, out_wen, e.res, e.dest, e.dest != 5'd0);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.res  = ref_alu(in_op, in_a, in_b);
        e.dest = in_dest;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL stream_leftover: %0d results never delivered, want 0", q.size());
    end
    checks++;
    if (n_xfer < 100) begin
      errors++;
      $display("FAIL stream_count: %0d transfers, want at least 100", n_xfer);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add_wrap();
    test_directed_ops();
    test_mul();
    test_backpressure();
    test_dest_zero();
    test_random_stream();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set and op presented.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 in_op  input  4  operation code.
REQ-008 in_a  input  DATA_W  operand A, from register-file read port 1.
REQ-009 in_b  input  DATA_W  operand B, from register-file read port 2.
REQ-010 in_dest  input  REG_AW  destination register index.
REQ-011 out_valid  output  1  result held for write-back.
REQ-012 out_ready  input  1  write-back consumer accepts the result.
REQ-013 out_result  output  DATA_W  result, feeds register-file write data.
REQ-014 out_dest  output  REG_AW  destination index, feeds register-file write address.
REQ-015 out_wen  output  1  out_valid AND out_dest != 0, feeds register-file write enable.

Function
REQ-016 Ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5 (signed, result 1 or 0), SLL=6, SRL=7 (logical), MUL=8; shift amount is in_b[4:0].
REQ-017 MUL returns the low DATA_W bits of in_a*in_b; ADD/SUB wrap modulo 2^DATA_W.
REQ-018 Undefined opcodes (9-15) return result 0 with normal single-cycle timing.
REQ-019 Transfer occurs on in_valid AND in_ready at a rising edge; the same rule applies to out_valid AND out_ready.
REQ-020 in_ready = (state==IDLE) AND (NOT out_valid OR out_ready), combinational; back-to-back single-cycle ops sustain 1 op/cycle.
REQ-021 FSM states: IDLE, MUL. IDLE->MUL on accepted MUL; MUL->IDLE when iteration counter reaches DATA_W-1.
REQ-022 A single-cycle op accepted at edge N drives out_valid=1 with its result from edge N+1.
REQ-023 MUL is iterative shift-add, one bit per cycle; an op accepted at edge N drives out_valid from edge N+DATA_W+1 (33 for default).
REQ-024 While out_valid=1 and out_ready=0, out_result, out_dest and out_valid hold stable.
REQ-025 out_valid falls on the edge of an output transfer unless a new result loads on that same edge.
REQ-026 During MUL, in_ready=0; operands and dest are captured at acceptance, so later input changes do not affect the result.
REQ-027 A MUL completing while the previous result is still unaccepted stalls in MUL at the last iteration until the output register frees.

Reset
REQ-028 rst_n low asynchronously forces state=IDLE, counter=0, out_valid=0, out_result=0, out_dest=0.
REQ-029 Reset mid-MUL discards the operation; no result is produced after release.
REQ-030 in_ready is 1 on the first edge after rst_n deasserts.

Structure
REQ-031 Opcode constants, the DATA_W/REG_AW defaults and the FSM state encoding reside in shared package alu_pkg.
REQ-032 The iterative multiplier is sub-module mul_iter (start, a, b -> busy, done, product); all other ops are inline combinational logic feeding the output register.

Verification
REQ-033 Reset release, then ADD a=0xFFFFFFFF, b=1, dest=3 -> next cycle out_valid=1, out_result=0, out_wen=1.
REQ-034 SLT a=0xFFFFFFFE (-2), b=1 -> result 1; SRL a=0x80000000, b=31 -> result 1; SLL b=0x23 -> shift by 3.
REQ-035 MUL a=0x00012345, b=0x00010000 -> in_ready=0 for 32 cycles; out_valid at cycle 33 with result 0x23450000.
REQ-036 Hold out_ready=0 for 5 cycles after an ADD result -> outputs stable, in_ready=0; release -> next op accepted the same cycle.
REQ-037 Assert rst_n=0 at MUL iteration 10 -> out_valid=0 immediately; after release no stale result appears within 40 cycles.
REQ-038 dest=0 with OR a=5, b=2 -> out_result=7, out_valid=1, out_wen=0.
